add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_add_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// Sequential W-bit add/subtract controller: walks N-bit words of A and B through an
// external N-bit adder, least-significant word first, and registers sum, carry and overflow.
module add_seq_ctrl #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [N*WORDS-1:0]   a_in,
    input  logic [N*WORDS-1:0]   b_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum_out,
    output logic                 cout,
    output logic                 of,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic                 add_cin,
    input  logic [N-1:0]         add_s,
    input  logic                 add_cout
);

    localparam int W    = N * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   idx_reg;
    logic              carry_reg;
    logic              sub_reg;
    logic [W-1:0]      a_reg, b_reg;
    logic [N-1:0]      a_word [WORDS];
    logic [N-1:0]      b_word [WORDS];
    logic              last_word;
    logic              top_a, top_b;

    // Word views of the latched operands so the active word is a simple array select.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
        assign a_word[gi] = a_reg[gi*N +: N];
        assign b_word[gi] = b_reg[gi*N +: N];
    end

    assign last_word = (idx_reg == LAST);
    assign top_a     = a_reg[W-1];
    assign top_b     = b_reg[W-1] ^ sub_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_reg)
            RUN: begin
                busy    = 1'b1;
                add_a   = a_word[idx_reg];
                add_b   = b_word[idx_reg] ^ {N{sub_reg}};
                add_cin = carry_reg;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            cout      <= 1'b0;
            of        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        sub_reg   <= sub;
                        idx_reg   <= '0;
                        carry_reg <= sub;
                    end
                end
                RUN: begin
                    carry_reg <= add_cout;
                    if (last_word) begin
                        // Index wraps here so it never exceeds the last word.
                        idx_reg <= '0;
                        cout    <= add_cout;
                        of      <= (top_a == top_b) && (add_s[N-1] != top_a);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_sum
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_out[gi*N +: N] <= '0;
            end else if (state_reg == RUN && idx_reg == IDXW'(gi)) begin
                sum_out[gi*N +: N] <= add_s;
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl with a 4-bit-block carry-skip adder as the external adder
// and a behavioural W-bit reference model.
module tb_add_seq_ctrl;

    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           sub = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           busy, done, cout, of;
    logic [W-1:0]   sum_out;
    logic [N-1:0]   add_a, add_b, add_s;
    logic           add_cin, add_cout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout     (cout),
        .of       (of),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Carry-skip adder: ripple inside 4-bit blocks, block carry bypassed when all bits propagate.
    always_comb begin
        logic c, rc, p, x;
        c     = add_cin;
        rc    = 1'b0;
        p     = 1'b0;
        x     = 1'b0;
        add_s = '0;
        for (int k = 0; k < N/4; k++) begin
            rc = c;
            p  = 1'b1;
            for (int j = 0; j < 4; j++) begin
                x = add_a[4*k+j] ^ add_b[4*k+j];
                add_s[4*k+j] = x ^ rc;
                rc = (add_a[4*k+j] & add_b[4*k+j]) | (x & rc);
                p  = p & x;
            end
            c = p ? c : rc;
        end
        add_cout = c;
    end

    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, b, input logic s);
        logic [W-1:0] be;
        logic [W:0]   r;
        logic         o;
        be = b ^ {W{s}};
        r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, s};
        o  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        return {o, r};
    endfunction

    task automatic chk(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation; optionally pulses start with other operands at RUN cycle inj (0 = none).
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_of, input int inj);
        int          cyc;
        logic        got;
        logic [W+1:0] m;
        m = ref_model(a, b, s);
        @(negedge clk);
        a_in = a; b_in = b; sub = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (cyc <= 20 && !got) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (cyc == 1) begin
                    chk({tag, "_add_a"}, {2'b0, {(W-N){1'b0}}, add_a}, {2'b0, {(W-N){1'b0}}, a[N-1:0]});
                    chk({tag, "_add_b"}, {2'b0, {(W-N){1'b0}}, add_b},
                        {2'b0, {(W-N){1'b0}}, b[N-1:0] ^ {N{s}}});
                    chk({tag, "_add_cin"}, {{(W+1){1'b0}}, add_cin}, {{(W+1){1'b0}}, s});
                end
                if (inj != 0 && cyc == inj) begin
                    start = 1'b1; a_in = ~a; b_in = ~b; sub = ~s;
                end
                if (inj != 0 && cyc == inj + 1) start = 1'b0;
                if (cyc == 2) chk({tag, "_busy_run"}, {{(W+1){1'b0}}, busy}, {{(W+1){1'b0}}, 1'b1});
                @(posedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, (W+2)'(got ? cyc : 99), (W+2)'(WORDS + 1));
        chk({tag, "_busy_done"}, {{(W+1){1'b0}}, busy}, {{(W+1){1'b0}}, 1'b1});
        chk({tag, "_sum"}, {2'b0, sum_out}, {2'b0, e_sum});
        chk({tag, "_flags"}, {{W{1'b0}}, of, cout}, {{W{1'b0}}, e_of, e_cout});
        chk({tag, "_model"}, {of, cout, sum_out}, m);
        @(negedge clk);
        chk({tag, "_after"}, {{W{1'b0}}, busy, done}, '0);
        chk({tag, "_hold"}, {2'b0, sum_out}, {2'b0, e_sum});
        $display("op %s a=%h b=%h sub=%0d sum=%h cout=%0d of=%0d", tag, a, b, s, sum_out, cout, of);
    endtask

    initial begin
        int n;
        logic got;
        #2;
        chk("rst_outs", {busy, done, cout, of, add_cin}, '0);
        chk("rst_sum", {2'b0, sum_out}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_add", {1'b0, add_a, add_b, add_cin}, '0);

        run_op("ripple", 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
               128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 0);
        run_op("sub", 128'h5, 128'h7, 1'b1,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        run_op("ovf", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1, 0);
        run_op("ones", {W{1'b1}}, {W{1'b1}}, 1'b0,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 0);
        run_op("ignore", 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
               128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0,
               128'h1234_5678_9ABC_DF00_1122_3344_5566_7788, 1'b0, 1'b0, 2);

        // Reset in the middle of RUN, with idx at 2.
        @(negedge clk);
        a_in = 128'h9; b_in = 128'h3; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {busy, done, cout, of, add_cin}, '0);
        chk("midrst_sum", {2'b0, sum_out}, '0);
        chk("midrst_add", {1'b0, add_a, add_b, add_cin}, '0);
        $display("op midrst busy=%0d done=%0d sum=%h", busy, done, sum_out);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("postrst", 128'h5, 128'h7, 1'b0, 128'hC, 1'b0, 1'b0, 0);

        // start held high: back-to-back operations every WORDS+2 cycles.
        @(negedge clk);
        a_in = 128'h1; b_in = 128'h2; sub = 1'b0; start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        chk("b2b_first", {{(W+1){1'b0}}, got}, {{(W+1){1'b0}}, 1'b1});
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = done;
        end
        start = 1'b0;
        chk("b2b_period", (W+2)'(got ? n : 99), (W+2)'(WORDS + 2));
        chk("b2b_sum", {2'b0, sum_out}, {2'b0, 128'h3});
        $display("op b2b period=%0d sum=%h", n, sum_out);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle", {{W{1'b0}}, busy, done}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
